// File: rtl/ascii_to_ps2_seq_pkg.sv
// Shared constants, FSM encodings and scan-code helpers for the ASCII to PS/2 sequencer.
package ascii_to_ps2_seq_pkg;

   localparam logic [7:0] SHIFT_CODE_DEF = 8'h12;
   localparam logic [7:0] BREAK_CODE_DEF = 8'hF0;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_BS = 8'h08;
   localparam logic [7:0] ASCII_SP = 8'h20;

   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_LOOKUP  = 4'd1;
   localparam logic [3:0] ST_SH_MK   = 4'd2;
   localparam logic [3:0] ST_KEY_MK  = 4'd3;
   localparam logic [3:0] ST_BRK_F0  = 4'd4;
   localparam logic [3:0] ST_KEY_BRK = 4'd5;
   localparam logic [3:0] ST_SH_F0   = 4'd6;
   localparam logic [3:0] ST_SH_BRK  = 4'd7;
   localparam logic [3:0] ST_GAP     = 4'd8;

   typedef struct packed {
      logic       hit;
      logic       shift;
      logic [7:0] scan;
   } key_t;

   function automatic key_t mk_key(input logic shift, input logic [7:0] scan);
      return '{hit: 1'b1, shift: shift, scan: scan};
   endfunction

   // Set-2 make codes for 'a'..'z' by alphabet index.
   function automatic logic [7:0] letter_scan(input logic [4:0] idx);
      case (idx)
         5'd0:  return 8'h1C;  5'd1:  return 8'h32;  5'd2:  return 8'h21;
         5'd3:  return 8'h23;  5'd4:  return 8'h24;  5'd5:  return 8'h2B;
         5'd6:  return 8'h34;  5'd7:  return 8'h33;  5'd8:  return 8'h43;
         5'd9:  return 8'h3B;  5'd10: return 8'h42;  5'd11: return 8'h4B;
         5'd12: return 8'h3A;  5'd13: return 8'h31;  5'd14: return 8'h44;
         5'd15: return 8'h4D;  5'd16: return 8'h15;  5'd17: return 8'h2D;
         5'd18: return 8'h1B;  5'd19: return 8'h2C;  5'd20: return 8'h3C;
         5'd21: return 8'h2A;  5'd22: return 8'h1D;  5'd23: return 8'h22;
         5'd24: return 8'h35;  5'd25: return 8'h1A;
         default: return 8'h00;
      endcase
   endfunction

   // Set-2 make codes for the top-row digit keys '0'..'9'.
   function automatic logic [7:0] digit_scan(input logic [3:0] d);
      case (d)
         4'd0: return 8'h45;  4'd1: return 8'h16;  4'd2: return 8'h1E;
         4'd3: return 8'h26;  4'd4: return 8'h25;  4'd5: return 8'h2E;
         4'd6: return 8'h36;  4'd7: return 8'h3D;  4'd8: return 8'h3E;
         4'd9: return 8'h46;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/ascii_to_ps2_seq_lut.sv
// Combinational ASCII -> {hit, shift, scan} key lookup (US layout, scan set 2).
module ascii_to_key_lut
   import ascii_to_ps2_seq_pkg::*;
(
   input  logic [7:0] i_ascii,
   output logic       o_hit,
   output logic       o_shift,
   output logic [7:0] o_scan
);

   key_t k;

   // Decode ranges first, then the individual symbol keys.
   always_comb begin
      k = '0;
      if (i_ascii >= 8'h61 && i_ascii <= 8'h7A) begin
         k = mk_key(1'b0, letter_scan(5'(i_ascii - 8'h61)));
      end else if (i_ascii >= 8'h41 && i_ascii <= 8'h5A) begin
         k = mk_key(1'b1, letter_scan(5'(i_ascii - 8'h41)));
      end else if (i_ascii >= 8'h30 && i_ascii <= 8'h39) begin
         k = mk_key(1'b0, digit_scan(4'(i_ascii - 8'h30)));
      end else begin
         case (i_ascii)
            8'h29: k = mk_key(1'b1, 8'h45);   // )
            8'h21: k = mk_key(1'b1, 8'h16);   // !
            8'h40: k = mk_key(1'b1, 8'h1E);   // @
            8'h23: k = mk_key(1'b1, 8'h26);   // #
            8'h24: k = mk_key(1'b1, 8'h25);   // $
            8'h25: k = mk_key(1'b1, 8'h2E);   // %
            8'h5E: k = mk_key(1'b1, 8'h36);   // ^
            8'h26: k = mk_key(1'b1, 8'h3D);   // &
            8'h2A: k = mk_key(1'b1, 8'h3E);   // *
            8'h28: k = mk_key(1'b1, 8'h46);   // (
            8'h60: k = mk_key(1'b0, 8'h0E);   // `
            8'h7E: k = mk_key(1'b1, 8'h0E);   // ~
            8'h2D: k = mk_key(1'b0, 8'h4E);   // -
            8'h5F: k = mk_key(1'b1, 8'h4E);   // _
            8'h3D: k = mk_key(1'b0, 8'h55);   // =
            8'h2B: k = mk_key(1'b1, 8'h55);   // +
            8'h5B: k = mk_key(1'b0, 8'h54);   // [
            8'h7B: k = mk_key(1'b1, 8'h54);   // {
            8'h5D: k = mk_key(1'b0, 8'h5B);   // ]
            8'h7D: k = mk_key(1'b1, 8'h5B);   // }
            8'h5C: k = mk_key(1'b0, 8'h5D);   // backslash
            8'h7C: k = mk_key(1'b1, 8'h5D);   // |
            8'h3B: k = mk_key(1'b0, 8'h4C);   // ;
            8'h3A: k = mk_key(1'b1, 8'h4C);   // :
            8'h27: k = mk_key(1'b0, 8'h52);   // '
            8'h22: k = mk_key(1'b1, 8'h52);   // "
            8'h2C: k = mk_key(1'b0, 8'h41);   // ,
            8'h3C: k = mk_key(1'b1, 8'h41);   // <
            8'h2E: k = mk_key(1'b0, 8'h49);   // .
            8'h3E: k = mk_key(1'b1, 8'h49);   // >
            8'h2F: k = mk_key(1'b0, 8'h4A);   // /
            8'h3F: k = mk_key(1'b1, 8'h4A);   // ?
            ASCII_SP: k = mk_key(1'b0, 8'h29);
            ASCII_CR: k = mk_key(1'b0, 8'h5A);
            ASCII_BS: k = mk_key(1'b0, 8'h66);
            default:  k = '0;
         endcase
      end
   end

   assign o_hit   = k.hit;
   assign o_shift = k.shift;
   assign o_scan  = k.scan;

endmodule

// File: rtl/ascii_to_ps2_seq.sv
// ASCII character -> PS/2 set-2 make/break byte sequence over a valid/ready byte stream.
module ascii_to_ps2_seq
   import ascii_to_ps2_seq_pkg::*;
#(
   parameter logic [7:0]  SHIFT_CODE = SHIFT_CODE_DEF,
   parameter logic [7:0]  BREAK_CODE = BREAK_CODE_DEF,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_ascii,
   input  logic       i_valid,
   output logic       o_ready,
   output logic [7:0] o_tx_byte,
   output logic       o_tx_valid,
   input  logic       i_tx_ready,
   output logic       o_busy,
   output logic       o_err
);

   localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   logic [3:0]    state_q;
   logic [3:0]    ret_q;
   logic [7:0]    char_q;
   logic [CW-1:0] gap_q;
   logic          hit;
   logic          shift;
   logic [7:0]    scan;
   logic [3:0]    first_st;
   logic [3:0]    nxt_st;

   ascii_to_key_lut u_lut (
      .i_ascii (char_q),
      .o_hit   (hit),
      .o_shift (shift),
      .o_scan  (scan)
   );

   function automatic logic [7:0] byte_of(input logic [3:0] st, input logic [7:0] sc);
      case (st)
         ST_SH_MK, ST_SH_BRK: return SHIFT_CODE;
         ST_BRK_F0, ST_SH_F0: return BREAK_CODE;
         default:             return sc;
      endcase
   endfunction

   // Entry state and successor byte state; IDLE as successor marks the last byte.
   always_comb begin
      first_st = shift ? ST_SH_MK : ST_KEY_MK;
      case (state_q)
         ST_SH_MK:   nxt_st = ST_KEY_MK;
         ST_KEY_MK:  nxt_st = ST_BRK_F0;
         ST_BRK_F0:  nxt_st = ST_KEY_BRK;
         ST_KEY_BRK: nxt_st = shift ? ST_SH_F0 : ST_IDLE;
         ST_SH_F0:   nxt_st = ST_SH_BRK;
         default:    nxt_st = ST_IDLE;
      endcase
   end

   // Sequencer FSM with registered byte output and inter-byte gap counter.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         ret_q      <= ST_IDLE;
         char_q     <= '0;
         gap_q      <= '0;
         o_tx_byte  <= '0;
         o_tx_valid <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_valid) begin
                  char_q  <= i_ascii;
                  state_q <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (hit) begin
                  state_q    <= first_st;
                  o_tx_byte  <= byte_of(first_st, scan);
                  o_tx_valid <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_GAP: begin
               if (gap_q == '0) begin
                  state_q    <= ret_q;
                  o_tx_byte  <= byte_of(ret_q, scan);
                  o_tx_valid <= 1'b1;
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end
            ST_SH_MK, ST_KEY_MK, ST_BRK_F0, ST_KEY_BRK, ST_SH_F0, ST_SH_BRK: begin
               if (i_tx_ready) begin
                  if (nxt_st == ST_IDLE) begin
                     state_q    <= ST_IDLE;
                     o_tx_valid <= 1'b0;
                  end else if (GAP_CYCLES > 0) begin
                     // Counter runs GAP_CYCLES-1 down to 0, giving exactly GAP_CYCLES idle cycles.
                     state_q    <= ST_GAP;
                     ret_q      <= nxt_st;
                     gap_q      <= CW'(GAP_CYCLES - 1);
                     o_tx_valid <= 1'b0;
                  end else begin
                     state_q   <= nxt_st;
                     o_tx_byte <= byte_of(nxt_st, scan);
                  end
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               o_tx_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready = (state_q == ST_IDLE);
   assign o_busy  = (state_q != ST_IDLE);
   assign o_err   = (state_q == ST_LOOKUP) && !hit;

endmodule
